// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline stages and the central pipeline controller.
// master: controller side (pipe_ctrl); slave: pipeline stage side.
interface pipe_ctrl_if;
   logic        stallreq_if;
   logic        stallreq_id;
   logic        stallreq_ex;
   logic        stallreq_mem;
   logic        br_req;
   logic [31:0] br_target;
   logic [5:0]  stall;
   logic        flush_ifid;
   logic        flush_idex;
   logic        pc_redirect;
   logic [31:0] pc_target;
   logic [31:0] stall_cycles;
   logic [31:0] flush_count;

   modport master (
      input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, br_req, br_target,
      output stall, flush_ifid, flush_idex, pc_redirect, pc_target, stall_cycles, flush_count
   );

   modport slave (
      output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem, br_req, br_target,
      input  stall, flush_ifid, flush_idex, pc_redirect, pc_target, stall_cycles, flush_count
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/redirect controller for the five-stage core.
// Optional performance counters enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl (
   input  logic          clk,
   input  logic          rst,
   pipe_ctrl_if.master   bus
);
   typedef enum logic {RUN, PEND} state_t;

   state_t      state_reg, state_next;
   logic [31:0] pend_reg, pend_next;
   logic [5:0]  stall_base;
   logic [5:0]  stall_int;
   logic        br_acc;
   logic        flush_ifid_int, flush_idex_int, redirect_int;
   logic [31:0] target_int;

   // Highest requesting stage wins; bit 5 is reserved.
   always_comb begin
      stall_base = 6'b000000;
      if (bus.stallreq_mem)     stall_base = 6'b011111;
      else if (bus.stallreq_ex) stall_base = 6'b001111;
      else if (bus.stallreq_id) stall_base = 6'b000111;
      else if (bus.stallreq_if) stall_base = 6'b000011;
   end

   // A branch is only real when EX actually advances; otherwise EX re-presents it.
   assign br_acc = bus.br_req & ~stall_base[3];

   always_comb begin
      state_next     = state_reg;
      pend_next      = pend_reg;
      stall_int      = stall_base;
      flush_ifid_int = 1'b0;
      flush_idex_int = 1'b0;
      redirect_int   = 1'b0;
      target_int     = pend_reg;
      case (state_reg)
         RUN: begin
            if (br_acc) begin
               flush_ifid_int = 1'b1;
               flush_idex_int = 1'b1;
               if (!bus.stallreq_if) begin
                  redirect_int = 1'b1;
                  target_int   = bus.br_target;
               end else begin
                  pend_next  = bus.br_target;
                  state_next = PEND;
               end
            end
         end
         PEND: begin
            // PC frozen and wrong-path fetch discarded until IF is free.
            stall_int[0]   = 1'b1;
            flush_ifid_int = 1'b1;
            if (br_acc) begin
               flush_idex_int = 1'b1;
               pend_next      = bus.br_target;
            end
            if (!bus.stallreq_if) begin
               redirect_int = 1'b1;
               target_int   = br_acc ? bus.br_target : pend_reg;
               state_next   = RUN;
            end
         end
         default: state_next = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= RUN;
         pend_reg  <= 32'h0;
      end else begin
         state_reg <= state_next;
         pend_reg  <= pend_next;
      end
   end

   assign bus.stall       = stall_int;
   assign bus.flush_ifid  = flush_ifid_int;
   assign bus.flush_idex  = flush_idex_int;
   assign bus.pc_redirect = redirect_int;
   assign bus.pc_target   = target_int;

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cycles_reg, flush_count_reg;

   // Saturating counters: stall cycles use the final vector including the PEND hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_reg <= 32'h0;
         flush_count_reg  <= 32'h0;
      end else begin
         if ((stall_int != 6'b0) && (stall_cycles_reg != 32'hFFFF_FFFF))
            stall_cycles_reg <= stall_cycles_reg + 32'd1;
         if (redirect_int && (flush_count_reg != 32'hFFFF_FFFF))
            flush_count_reg <= flush_count_reg + 32'd1;
      end
   end

   assign bus.stall_cycles = stall_cycles_reg;
   assign bus.flush_count  = flush_count_reg;
`else
   assign bus.stall_cycles = 32'h0;
   assign bus.flush_count  = 32'h0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl; counter expectations follow PIPE_CTRL_PERF_EN.
module tb_pipe_ctrl;
   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   pipe_ctrl_if bus ();

   pipe_ctrl u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] cnt(input int v);
`ifdef PIPE_CTRL_PERF_EN
      return v;
`else
      return 32'h0 + (v & 0);
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [5:0] st, input logic fi, input logic fd,
                          input logic rd, input logic [31:0] tg);
      chk({tag, ".stall"},       {26'h0, bus.stall}, {26'h0, st});
      chk({tag, ".flush_ifid"},  {31'h0, bus.flush_ifid}, {31'h0, fi});
      chk({tag, ".flush_idex"},  {31'h0, bus.flush_idex}, {31'h0, fd});
      chk({tag, ".pc_redirect"}, {31'h0, bus.pc_redirect}, {31'h0, rd});
      chk({tag, ".pc_target"},   bus.pc_target, tg);
   endtask

   task automatic chk_cnt(input string tag, input int sc, input int fc);
      chk({tag, ".stall_cycles"}, bus.stall_cycles, cnt(sc));
      chk({tag, ".flush_count"},  bus.flush_count,  cnt(fc));
   endtask

   task automatic drive(input logic sif, input logic sid, input logic sex, input logic smem,
                        input logic br, input logic [31:0] tgt);
      bus.stallreq_if  = sif;
      bus.stallreq_id  = sid;
      bus.stallreq_ex  = sex;
      bus.stallreq_mem = smem;
      bus.br_req       = br;
      bus.br_target    = tgt;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 32'h0);
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      drive(0, 0, 0, 0, 0, 32'h0);
      chk_out("reset", 6'b000000, 0, 0, 0, 32'h0);
      chk_cnt("reset", 0, 0);
      tick();

      // Stall priority
      drive(1, 0, 1, 0, 0, 32'h0);
      chk_out("prio_if_ex", 6'b001111, 0, 0, 0, 32'h0);
      tick();
      drive(1, 0, 1, 1, 0, 32'h0);
      chk_out("prio_mem", 6'b011111, 0, 0, 0, 32'h0);
      tick();
      drive(0, 0, 0, 0, 0, 32'h0);
      chk_out("prio_none", 6'b000000, 0, 0, 0, 32'h0);
      chk_cnt("after_prio", 2, 0);
      tick();

      // Branch with IF idle: same-cycle redirect
      drive(0, 0, 0, 0, 1, 32'h0000_0100);
      chk_out("br_idle", 6'b000000, 1, 1, 1, 32'h100);
      tick();
      drive(0, 0, 0, 0, 0, 32'h0);
      chk_out("br_idle_next", 6'b000000, 0, 0, 0, 32'h0);
      chk_cnt("br_idle_next", 2, 1);
      tick();

      // Branch under EX stall is ignored
      drive(0, 0, 1, 0, 1, 32'h0000_0500);
      chk_out("br_exstall", 6'b001111, 0, 0, 0, 32'h0);
      tick();

      // Simultaneous MEM stall and branch: ignored
      drive(0, 0, 0, 1, 1, 32'h0000_0600);
      chk_out("br_memstall", 6'b011111, 0, 0, 0, 32'h0);
      tick();

      // Branch during fetch: pend until IF free
      drive(1, 0, 0, 0, 1, 32'h0000_0200);
      chk_out("pend_c0", 6'b000011, 1, 1, 0, 32'h0);
      tick();
      drive(1, 0, 0, 0, 0, 32'h0);
      chk_out("pend_c1", 6'b000011, 1, 0, 0, 32'h200);
      tick();
      drive(1, 0, 0, 0, 0, 32'h0);
      chk_out("pend_c2", 6'b000011, 1, 0, 0, 32'h200);
      tick();
      drive(0, 0, 0, 0, 0, 32'h0);
      chk_out("pend_release", 6'b000001, 1, 0, 1, 32'h200);
      tick();
      drive(0, 0, 0, 0, 0, 32'h0);
      chk_out("pend_after", 6'b000000, 0, 0, 0, 32'h200);
      chk_cnt("pend_after", 8, 2);
      tick();

      // New branch while pending overwrites target; release uses live target
      drive(1, 0, 0, 0, 1, 32'h0000_0300);
      chk_out("ovr_c0", 6'b000011, 1, 1, 0, 32'h200);
      tick();
      drive(1, 0, 0, 0, 1, 32'h0000_0340);
      chk_out("ovr_c1", 6'b000011, 1, 1, 0, 32'h300);
      tick();
      drive(1, 0, 0, 0, 0, 32'h0);
      chk_out("ovr_c2", 6'b000011, 1, 0, 0, 32'h340);
      tick();
      drive(0, 0, 0, 0, 1, 32'h0000_0380);
      chk_out("ovr_release", 6'b000001, 1, 1, 1, 32'h380);
      tick();
      drive(0, 0, 0, 0, 0, 32'h0);
      chk_out("ovr_after", 6'b000000, 0, 0, 0, 32'h380);
      chk_cnt("ovr_after", 12, 3);
      tick();

      // Reset while pending discards the redirect
      drive(1, 0, 0, 0, 1, 32'h0000_0300);
      chk_out("rst_pend_c0", 6'b000011, 1, 1, 0, 32'h380);
      tick();
      rst = 1'b1;
      drive(1, 0, 0, 0, 0, 32'h0);
      tick();
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 32'h0);
      chk_out("rst_pend_after", 6'b000000, 0, 0, 0, 32'h0);
      chk_cnt("rst_pend_after", 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 32'h0);
      chk_out("rst_pend_next", 6'b000000, 0, 0, 0, 32'h0);
      tick();

      // Counters: 4 stall cycles and 2 redirects
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 0, 0, 0, 32'h0);
         if (i == 0) chk_out("perf_id", 6'b000111, 0, 0, 0, 32'h0);
         tick();
      end
      drive(0, 0, 0, 0, 1, 32'h0000_0440);
      chk_out("perf_br0", 6'b000000, 1, 1, 1, 32'h440);
      tick();
      drive(0, 0, 0, 0, 1, 32'h0000_0480);
      chk_out("perf_br1", 6'b000000, 1, 1, 1, 32'h480);
      tick();
      drive(0, 0, 0, 0, 0, 32'h0);
      chk_cnt("perf_final", 4, 2);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
